// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. It drives imem requests from the current PC and registers IF/ID.
// Latency: id_* outputs update on the clock edge that ends the ack cycle. Zero-wait memory sustains one fetch per cycle.
// Backpressure: a stall that collides with an ack parks the fetch in a one-entry skid (HOLD); a flush without ack drains the stale response (DROP).
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   pc / pc_en / pc_plus4     PC register interface (pc_en loads the external next PC)
//   imem_req/addr/ack/rdata   instruction memory req/ack handshake
//   stall, flush              decode backpressure and redirect
//   id_valid/pc/instr/pc_plus4 registered IF/ID outputs
module fetch_unit #(
  parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_en,
  output logic [31:0] pc_plus4,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
);

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic        id_valid_nxt;
  logic [31:0] id_pc_nxt, id_instr_nxt, id_pc_plus4_nxt;
  logic [31:0] skid_pc, skid_pc_nxt, skid_instr, skid_instr_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic        free;

  assign pc_plus4 = pc + 32'd4;
  // IF/ID can take a new instruction when it is empty or decode is consuming it.
  assign free     = !id_valid || !stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_WAIT;
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_instr    <= RESET_INSTR;
      id_pc_plus4 <= 32'd4;
      skid_pc     <= 32'd0;
      skid_instr  <= RESET_INSTR;
      drop_addr   <= 32'd0;
    end else begin
      state       <= state_nxt;
      id_valid    <= id_valid_nxt;
      id_pc       <= id_pc_nxt;
      id_instr    <= id_instr_nxt;
      id_pc_plus4 <= id_pc_plus4_nxt;
      skid_pc     <= skid_pc_nxt;
      skid_instr  <= skid_instr_nxt;
      drop_addr   <= drop_addr_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    id_valid_nxt    = id_valid;
    id_pc_nxt       = id_pc;
    id_instr_nxt    = id_instr;
    id_pc_plus4_nxt = id_pc_plus4;
    skid_pc_nxt     = skid_pc;
    skid_instr_nxt  = skid_instr;
    drop_addr_nxt   = drop_addr;
    pc_en           = 1'b0;
    imem_req        = 1'b1;
    imem_addr       = pc;

    case (state)
      S_WAIT: begin
        if (flush) begin
          pc_en        = 1'b1;
          id_valid_nxt = 1'b0;
          id_instr_nxt = RESET_INSTR;
          // The request is still in flight; its response must be swallowed
          // and the address held until memory acks it.
          if (!imem_ack) begin
            drop_addr_nxt = pc;
            state_nxt     = S_DROP;
          end
        end else if (imem_ack) begin
          pc_en = 1'b1;
          if (free) begin
            id_valid_nxt    = 1'b1;
            id_pc_nxt       = pc;
            id_instr_nxt    = imem_rdata;
            id_pc_plus4_nxt = pc_plus4;
          end else begin
            skid_pc_nxt    = pc;
            skid_instr_nxt = imem_rdata;
            state_nxt      = S_HOLD;
          end
        end else if (free) begin
          id_valid_nxt = 1'b0;
        end
      end

      S_HOLD: begin
        imem_req = 1'b0;
        if (flush) begin
          pc_en          = 1'b1;
          id_valid_nxt   = 1'b0;
          id_instr_nxt   = RESET_INSTR;
          skid_pc_nxt    = 32'd0;
          skid_instr_nxt = RESET_INSTR;
          state_nxt      = S_WAIT;
        end else if (!stall) begin
          id_valid_nxt    = 1'b1;
          id_pc_nxt       = skid_pc;
          id_instr_nxt    = skid_instr;
          id_pc_plus4_nxt = skid_pc + 32'd4;
          skid_pc_nxt     = 32'd0;
          skid_instr_nxt  = RESET_INSTR;
          state_nxt       = S_WAIT;
        end
      end

      S_DROP: begin
        imem_addr = drop_addr;
        if (flush) begin
          pc_en        = 1'b1;
          id_valid_nxt = 1'b0;
          id_instr_nxt = RESET_INSTR;
        end else if (imem_ack) begin
          state_nxt = S_WAIT;
        end
      end

      default: state_nxt = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_en;
  logic [31:0] pc_plus4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;

  int n_total = 0;
  int n_pass  = 0;

  fetch_unit #(.RESET_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_en(pc_en), .pc_plus4(pc_plus4),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rd;
    logic        stall;
    logic        flush;
    logic        e_en;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_idpc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[28];

  function automatic logic [31:0] tg(input logic [31:0] a);
    return a ^ 32'h5A00_0000;
  endfunction

  function automatic vec_t mk(input logic [31:0] p, input logic a, input logic [31:0] r,
                              input logic s, input logic f, input logic en, input logic rq,
                              input logic [31:0] ad, input logic v, input logic [31:0] ip,
                              input logic [31:0] ins);
    vec_t t;
    t.pc = p; t.ack = a; t.rd = r; t.stall = s; t.flush = f;
    t.e_en = en; t.e_req = rq; t.e_addr = ad; t.e_vld = v; t.e_idpc = ip; t.e_instr = ins;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  initial begin
    //            pc            ack rdata           st fl  en req addr          vld id_pc         id_instr
    tbl[0]  = mk(32'h0,        1, tg(32'h0),      0, 0,  1, 1, 32'h0,        1, 32'h0,        tg(32'h0));
    tbl[1]  = mk(32'h4,        1, tg(32'h4),      0, 0,  1, 1, 32'h4,        1, 32'h4,        tg(32'h4));
    tbl[2]  = mk(32'h8,        1, tg(32'h8),      0, 0,  1, 1, 32'h8,        1, 32'h8,        tg(32'h8));
    tbl[3]  = mk(32'hC,        0, JUNK,           0, 0,  0, 1, 32'hC,        0, 32'h8,        tg(32'h8));
    tbl[4]  = mk(32'hC,        0, JUNK,           0, 0,  0, 1, 32'hC,        0, 32'h8,        tg(32'h8));
    tbl[5]  = mk(32'hC,        1, tg(32'hC),      0, 0,  1, 1, 32'hC,        1, 32'hC,        tg(32'hC));
    tbl[6]  = mk(32'h10,       0, JUNK,           0, 0,  0, 1, 32'h10,       0, 32'hC,        tg(32'hC));
    tbl[7]  = mk(32'h10,       1, tg(32'h10),     0, 0,  1, 1, 32'h10,       1, 32'h10,       tg(32'h10));
    tbl[8]  = mk(32'h14,       1, tg(32'h14),     0, 0,  1, 1, 32'h14,       1, 32'h14,       tg(32'h14));
    // stall collides with ack: fetch of 0x18 parks in the skid
    tbl[9]  = mk(32'h18,       1, tg(32'h18),     1, 0,  1, 1, 32'h18,       1, 32'h14,       tg(32'h14));
    tbl[10] = mk(32'h1C,       0, JUNK,           1, 0,  0, 0, 32'h0,        1, 32'h14,       tg(32'h14));
    tbl[11] = mk(32'h1C,       0, JUNK,           0, 0,  0, 0, 32'h0,        1, 32'h18,       tg(32'h18));
    tbl[12] = mk(32'h1C,       1, tg(32'h1C),     0, 0,  1, 1, 32'h1C,       1, 32'h1C,       tg(32'h1C));
    tbl[13] = mk(32'h20,       0, JUNK,           1, 0,  0, 1, 32'h20,       1, 32'h1C,       tg(32'h1C));
    // flush without ack: DROP holds address 0x20 until the stale ack
    tbl[14] = mk(32'h20,       0, JUNK,           0, 1,  1, 1, 32'h20,       0, 32'h1C,       NOP);
    tbl[15] = mk(32'h100,      0, JUNK,           0, 0,  0, 1, 32'h20,       0, 32'h1C,       NOP);
    tbl[16] = mk(32'h100,      1, JUNK,           0, 0,  0, 1, 32'h20,       0, 32'h1C,       NOP);
    tbl[17] = mk(32'h100,      1, tg(32'h100),    0, 0,  1, 1, 32'h100,      1, 32'h100,      tg(32'h100));
    // flush and stall together while the skid is full
    tbl[18] = mk(32'h104,      1, tg(32'h104),    1, 0,  1, 1, 32'h104,      1, 32'h100,      tg(32'h100));
    tbl[19] = mk(32'h108,      0, JUNK,           1, 1,  1, 0, 32'h0,        0, 32'h100,      NOP);
    tbl[20] = mk(32'h200,      1, tg(32'h200),    0, 0,  1, 1, 32'h200,      1, 32'h200,      tg(32'h200));
    // flush with ack (and stall) in WAIT: response discarded, no DROP
    tbl[21] = mk(32'h204,      1, tg(32'h204),    1, 1,  1, 1, 32'h204,      0, 32'h200,      NOP);
    tbl[22] = mk(32'h300,      0, JUNK,           0, 0,  0, 1, 32'h300,      0, 32'h200,      NOP);
    // flush again while in DROP keeps the original drop address
    tbl[23] = mk(32'h300,      0, JUNK,           0, 1,  1, 1, 32'h300,      0, 32'h200,      NOP);
    tbl[24] = mk(32'h400,      0, JUNK,           0, 1,  1, 1, 32'h300,      0, 32'h200,      NOP);
    tbl[25] = mk(32'h400,      1, JUNK,           0, 0,  0, 1, 32'h300,      0, 32'h200,      NOP);
    tbl[26] = mk(32'h400,      1, tg(32'h400),    0, 0,  1, 1, 32'h400,      1, 32'h400,      tg(32'h400));
    tbl[27] = mk(32'hFFFF_FFFC, 1, tg(32'hFFFF_FFFC), 0, 0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, tg(32'hFFFF_FFFC));

    rst = 1'b1; pc = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0; stall = 1'b0; flush = 1'b0;
    #2;
    chk("reset id_valid", {31'd0, id_valid}, 32'd0);
    chk("reset id_pc", id_pc, 32'd0);
    chk("reset id_pc_plus4", id_pc_plus4, 32'd4);
    chk("reset id_instr", id_instr, NOP);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      pc = tbl[i].pc; imem_ack = tbl[i].ack; imem_rdata = tbl[i].rd;
      stall = tbl[i].stall; flush = tbl[i].flush;
      #2;
      chk($sformatf("s%0d pc_en", i), {31'd0, pc_en}, {31'd0, tbl[i].e_en});
      chk($sformatf("s%0d imem_req", i), {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("s%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("s%0d pc_plus4", i), pc_plus4, tbl[i].pc + 32'd4);
      @(posedge clk);
      #1;
      chk($sformatf("s%0d id_valid", i), {31'd0, id_valid}, {31'd0, tbl[i].e_vld});
      chk($sformatf("s%0d id_pc", i), id_pc, tbl[i].e_idpc);
      chk($sformatf("s%0d id_pc_plus4", i), id_pc_plus4, tbl[i].e_idpc + 32'd4);
      chk($sformatf("s%0d id_instr", i), id_instr, tbl[i].e_instr);
    end
    chk("wrap id_pc_plus4", id_pc_plus4, 32'h0);

    // Enter DROP, then assert reset between edges.
    pc = 32'h500; imem_ack = 1'b0; stall = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; pc = 32'h600;
    #1;
    chk("drop holds addr", imem_addr, 32'h500);
    rst = 1'b1;
    #1;
    chk("async rst id_valid", {31'd0, id_valid}, 32'd0);
    chk("async rst id_pc", id_pc, 32'd0);
    chk("async rst id_pc_plus4", id_pc_plus4, 32'd4);
    chk("async rst id_instr", id_instr, NOP);
    chk("async rst imem_addr", imem_addr, 32'h600);
    chk("async rst pc_en", {31'd0, pc_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0; pc = 32'h0; imem_ack = 1'b1; imem_rdata = tg(32'h0);
    #1;
    chk("post rst imem_req", {31'd0, imem_req}, 32'd1);
    chk("post rst imem_addr", imem_addr, 32'h0);
    chk("post rst pc_en", {31'd0, pc_en}, 32'd1);
    @(posedge clk);
    #1;
    chk("post rst id_valid", {31'd0, id_valid}, 32'd1);
    chk("post rst id_instr", id_instr, tg(32'h0));
    imem_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-level pipeline, placed directly downstream of the PC register. Reads the current PC and issues instruction-memory requests over a req/ack handshake. Returns `pc_en` to the PC register so it advances only when a fetch is accepted or a redirect occurs. Produces the registered IF/ID outputs, with a one-entry skid buffer for decode stalls and a drop state that discards in-flight responses after a flush.

## Interface
Parameters:
- RESET_INSTR, 32'h0000_0000, value of `id_instr` and skid entry after reset/flush (NOP)

Ports:
- clk  in  1  single clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- pc  in  32  current PC from PC register
- pc_en  out  1  enable to PC register (loads external pc_new)
- pc_plus4  out  32  pc + 4 (mod 2^32), combinational, feeds next-PC mux
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request address
- imem_ack  in  1  memory completes request this cycle
- imem_rdata  in  32  instruction, valid only when imem_ack=1
- stall  in  1  decode cannot accept a new instruction
- flush  in  1  redirect: discard fetched/in-flight work; pc_new carries target
- id_valid  out  1  IF/ID entry valid
- id_pc  out  32  PC of IF/ID instruction
- id_instr  out  32  IF/ID instruction
- id_pc_plus4  out  32  id_pc + 4

## Operation
- States: WAIT (request outstanding), HOLD (skid full, no request), DROP (discarding stale response). Reset state WAIT.
- Output register "free" = !id_valid || !stall.
- WAIT: imem_req=1, imem_addr=pc.
  - ack, no flush, free: load id_pc=pc, id_instr=imem_rdata, id_valid=1, pc_en=1; stay WAIT.
  - ack, no flush, not free: capture {pc, rdata} in skid, pc_en=1; go HOLD.
  - no ack, no flush: hold outputs unless free (then id_valid<=0 when !stall); pc_en=0.
  - flush with ack: discard rdata, id_valid<=0, pc_en=1; stay WAIT.
  - flush without ack: drop_addr<=pc, id_valid<=0, pc_en=1; go DROP.
- HOLD: imem_req=0, pc_en=0. When !stall: IF/ID loads skid, id_valid=1, skid cleared; go WAIT. Flush: clear id_valid and skid, pc_en=1; go WAIT.
- DROP: imem_req=1, imem_addr=drop_addr (stable until ack). On ack: discard rdata; go WAIT. Flush in DROP: pc_en=1, stay DROP, drop_addr unchanged.
- Flush has priority over stall and ack in every state. id_valid cleared on flush regardless of stall.
- pc_en=1 only in the cases listed above; otherwise 0.
- id_pc_plus4 is registered alongside id_pc; wraps 32'hFFFF_FFFC -> 0.
- Reset mid-request: state WAIT, outstanding request forgotten. Memory must not ack a pre-reset request after reset.

## Timing
- Reset values: id_valid=0, id_pc=0, id_pc_plus4=4, id_instr=RESET_INSTR, skid empty, state WAIT.
- First cycle after reset release: imem_req=1, imem_addr=pc (0).
- imem_req, imem_addr, pc_en and pc_plus4 are combinational from state and inputs. pc_en is asserted in the same cycle as the qualifying ack or flush.
- id_* outputs update on the posedge ending the ack cycle (1-cycle latency from ack).
- Zero-wait memory (ack in the request cycle) sustains 1 instruction/cycle.
- imem_addr must not change while imem_req=1 and imem_ack=0. This holds because pc_en=0 in that case and DROP uses drop_addr.
- HOLD -> WAIT costs one bubble cycle with no request.

## Test plan
- Reset, zero-wait memory returning addr-tagged data, pc_new=pc+4: id_pc = 0,4,8,… on consecutive cycles, id_valid=1 from cycle 2, pc_en=1 every cycle.
- 3-cycle memory latency: imem_addr=0 held three cycles, pc_en pulses once per ack, id_valid drops between fetches.
- stall=1 with id_valid=1, ack for pc=8: skid holds pc=8, imem_req=0, IF/ID stays pc=4. On stall=0, IF/ID shows pc=8 next cycle, then requests resume at 12.
- flush in WAIT without ack (pc=16, target 0x100): pc_en=1, DROP keeps imem_addr=16 until ack, response discarded, next request imem_addr=0x100, id_valid=0 throughout.
- flush and stall in HOLD simultaneously: id_valid=0, skid cleared, pc_en=1, WAIT next cycle, no stale instruction emitted.
- Wrap and async reset: pc=32'hFFFF_FFFC gives pc_plus4=0 and id_pc_plus4=0. rst asserted mid-DROP clears all outputs immediately, without waiting for a clock edge.
